// File: rtl/mac_pkg.sv
// Shared state encoding and latency constants for the MAC sequencer.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FETCH  = 3'd2,
    DRAIN1 = 3'd3,
    DRAIN2 = 3'd4,
    DONE   = 3'd5
  } mac_ctrl_state_t;

  localparam int RD_LAT   = 1;
  localparam int MAC_LAT  = 2;
  // Taps: RD_LAT-1 feeds the multiply register, the last tap feeds the accumulator.
  localparam int EN_DLY_W = RD_LAT + MAC_LAT - 1;

endpackage

// File: rtl/mac_ctrl.sv
// Dot-product sequencer: clears the MAC, streams len operand pairs through the
// shared buffer read port, drains the MAC pipeline and latches the result.
module mac_ctrl
  import mac_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int OUT_WIDTH  = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  input  logic [OUT_WIDTH-1:0]  mac_out,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  mac_rst_mem,
  output logic                  mac_mul_en,
  output logic                  mac_ac_en,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_WIDTH-1:0]  result
);

  localparam logic [ADDR_WIDTH:0]   MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ZERO_LEN = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   ONE_LEN  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  mac_ctrl_state_t       state;
  mac_ctrl_state_t       next_state;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   len_clamped;
  logic [EN_DLY_W-1:0]   en_dly;
  logic                  last_fetch;
  logic                  kill;

  assign kill       = abort && (state != IDLE);
  assign last_fetch = ({1'b0, rd_addr} == (len - ONE_LEN));
  assign mac_mul_en = en_dly[RD_LAT-1];
  assign mac_ac_en  = en_dly[EN_DLY_W-1];

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len > MAX_LEN) begin
      len_clamped = MAX_LEN;
    end else begin
      len_clamped = cfg_len;
    end
  end

  // Abort overrides every other transition outside IDLE.
  always_comb begin
    next_state = state;
    if (kill) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) next_state = CLEAR;
          else       next_state = IDLE;
        end
        CLEAR: begin
          if (len == ZERO_LEN) next_state = DONE;
          else                 next_state = FETCH;
        end
        FETCH: begin
          if (last_fetch) next_state = DRAIN1;
          else            next_state = FETCH;
        end
        DRAIN1:  next_state = DRAIN2;
        DRAIN2:  next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len         <= ZERO_LEN;
      rd_en       <= 1'b0;
      rd_addr     <= {ADDR_WIDTH{1'b0}};
      mac_rst_mem <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= {OUT_WIDTH{1'b0}};
    end else begin
      state       <= next_state;
      rd_en       <= (next_state == FETCH);
      mac_rst_mem <= (next_state == CLEAR);
      busy        <= (next_state != IDLE);
      done        <= (state == DONE) && !kill;
      if ((state == IDLE) && start) begin
        len <= len_clamped;
      end
      if ((state == FETCH) && (next_state == FETCH)) begin
        rd_addr <= rd_addr + ADDR_ONE;
      end else begin
        rd_addr <= {ADDR_WIDTH{1'b0}};
      end
      if ((state == DONE) && !kill) begin
        result <= mac_out;
      end
    end
  end

  // Enable delay line: tap 0 marks valid read data, the last tap marks a valid product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_dly <= {EN_DLY_W{1'b0}};
    end else if (kill || (state == CLEAR)) begin
      en_dly <= {EN_DLY_W{1'b0}};
    end else begin
      en_dly <= {en_dly[EN_DLY_W-2:0], rd_en};
    end
  end

endmodule

// File: tb/tb_mac_ctrl.sv
// Randomized self-checking bench for mac_ctrl with a buffer/MAC environment and
// a cycle-timeline reference model.
module tb_mac_ctrl;

  localparam int AW   = 6;
  localparam int OW   = 22;
  localparam int MAXN = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   cfg_len = '0;
  logic [OW-1:0] mac_out;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          mac_rst_mem;
  logic          mac_mul_en;
  logic          mac_ac_en;
  logic          busy;
  logic          done;
  logic [OW-1:0] result;

  int n_cmp = 0;
  int n_err = 0;
  logic [OW-1:0] exp_result = '0;

  always #5 clk = ~clk;

  mac_ctrl #(.ADDR_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_len(cfg_len),
    .mac_out(mac_out), .rd_en(rd_en), .rd_addr(rd_addr), .mac_rst_mem(mac_rst_mem),
    .mac_mul_en(mac_mul_en), .mac_ac_en(mac_ac_en), .busy(busy), .done(done),
    .result(result)
  );

  // Environment: shared-port buffers with 1-cycle read latency and a two-stage MAC.
  logic [7:0]    img [MAXN];
  logic [7:0]    wgt [MAXN];
  logic [7:0]    img_q = '0;
  logic [7:0]    wgt_q = '0;
  logic [15:0]   prod = '0;
  logic [OW-1:0] acc = '0;

  always @(posedge clk) begin
    if (rd_en) begin
      img_q <= img[rd_addr];
      wgt_q <= wgt[rd_addr];
    end
    if (mac_mul_en) prod <= img_q * wgt_q;
    if (mac_rst_mem)    acc <= '0;
    else if (mac_ac_en) acc <= acc + OW'(prod);
  end
  assign mac_out = acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dot(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(img[i]) * int'(wgt[i]);
    return s;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < MAXN; i++) begin
      img[i] = 8'($urandom);
      wgt[i] = 8'($urandom);
    end
  endtask

  function automatic logic [31:0] flags();
    return {26'd0, rd_en, mac_mul_en, mac_ac_en, mac_rst_mem, busy, done};
  endfunction

  // One operation from the cycle start is driven; abort_k/pulse_k < 0 means none.
  task automatic run_op(input int cfg, input int abort_k, input int pulse_k);
    int n, last_busy, done_k;
    bit killed;
    logic [5:0] expf;
    logic [OW-1:0] new_res;
    n         = (cfg > MAXN) ? MAXN : cfg;
    last_busy = (n == 0) ? 2 : n + 4;
    done_k    = last_busy + 1;
    killed    = (abort_k >= 1) && (abort_k <= last_busy);
    new_res   = killed ? exp_result : OW'(dot(n));
    cfg_len   = (AW+1)'(cfg);
    start     = 1'b1;
    abort     = (abort_k == 0);
    for (int k = 0; k <= done_k + 1; k++) begin
      bit live;
      @(negedge clk);
      live = !killed || (k <= abort_k);
      expf = {live && k >= 2 && k <= n + 1,
              live && k >= 3 && k <= n + 2,
              live && k >= 4 && k <= n + 3,
              live && k == 1,
              live && k >= 1 && k <= last_busy,
              live && k == done_k};
      chk("flags", flags(), {26'd0, expf});
      if (expf[5]) chk("rd_addr", 32'(rd_addr), 32'(k - 2));
      chk("result", 32'(result), 32'((k >= done_k) ? new_res : exp_result));
      @(posedge clk);
      #1;
      start = (k + 1 == pulse_k);
      abort = (k + 1 == abort_k);
    end
    start      = 1'b0;
    abort      = 1'b0;
    exp_result = new_res;
  endtask

  initial begin
    int res3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", flags(), 32'd0);
    chk("reset_addr", 32'(rd_addr), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_flags", flags(), 32'd0);

    for (int i = 0; i < MAXN; i++) begin
      img[i] = 8'(i + 1);
      wgt[i] = 8'(i + 5);
    end
    run_op(4, -1, -1);
    chk("dot70", 32'(result), 32'd70);

    for (int i = 0; i < MAXN; i++) begin
      img[i] = 8'd255;
      wgt[i] = 8'd255;
    end
    run_op(64, -1, -1);
    chk("full64", 32'(result), 32'd4161600);
    run_op(100, -1, -1);
    chk("clamp100", 32'(result), 32'd4161600);

    run_op(0, -1, -1);
    chk("len0", 32'(result), 32'd0);

    fill_random();
    run_op(9, -1, -1);
    run_op(6, 4, -1);
    run_op(0, -1, -1);
    fill_random();
    run_op(7, -1, -1);
    run_op(5, 0, -1);
    run_op(5, -1, 3);
    run_op(6, 2, -1);
    run_op(6, 9, -1);

    for (int t = 0; t < 14; t++) begin
      int c;
      int a;
      fill_random();
      c = int'($urandom_range(0, 127));
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 75)) : -1;
      run_op(c, a, -1);
    end

    fill_random();
    res3    = dot(3);
    cfg_len = 7'd3;
    start   = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      chk("b2b_done", 32'(done), 32'(k > 0 && (k % 8) == 0));
      chk("b2b_busy", 32'(busy), 32'((k % 8) != 0));
      if (k >= 8) chk("b2b_result", 32'(result), 32'(res3));
      @(posedge clk);
      #1;
      start = (k + 1 <= 32);
    end
    start      = 1'b0;
    exp_result = OW'(res3);

    fill_random();
    cfg_len = 7'd5;
    start   = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    @(negedge clk);
    chk("drain1_flags", flags(), 32'b011010);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_flags", flags(), 32'd0);
    chk("async_rst_addr", 32'(rd_addr), 32'd0);
    chk("async_rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_rst_flags", flags(), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_ctrl.md
# mac_ctrl

Sequencer for a single MAC datapath (8-bit image × 8-bit weight, 22-bit accumulator with synchronous clear and separate multiply and accumulate enables). On `start` it clears the MAC and streams `cfg_len` operand pairs from the image and weight buffers, which share one synchronous read port with 1-cycle latency. It then drains the MAC's two-stage pipeline, latches the dot product and pulses `done`. It sits between the layer-level scheduler and one MAC/buffer pair.

## Interface
- `ADDR_WIDTH`, 6: buffer address width; maximum vector length is 2^ADDR_WIDTH.
- `OUT_WIDTH`, 22: MAC output and result width.
- `clk` input, 1: single clock. All logic is on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: request a dot product. Sampled only in IDLE.
- `abort` input, 1: cancel the operation in progress.
- `cfg_len` input, ADDR_WIDTH+1: vector length. Latched when `start` is accepted.
- `mac_out` input, OUT_WIDTH: MAC accumulator value.
- `rd_en` output, 1: buffer read strobe.
- `rd_addr` output, ADDR_WIDTH: buffer read address.
- `mac_rst_mem` output, 1: MAC synchronous clear.
- `mac_mul_en` output, 1: MAC multiply-register enable.
- `mac_ac_en` output, 1: MAC accumulate enable.
- `busy` output, 1: high in any state other than IDLE.
- `done` output, 1: 1-cycle completion pulse.
- `result` output, OUT_WIDTH: last completed dot product. Held until the next completion.

## Operation
- Reset value of every output is 0. After reset the state is IDLE and the length and address counters are 0.
- FSM states and transitions:
  - IDLE: `start` → CLEAR.
  - CLEAR: `mac_rst_mem`=1 for exactly 1 cycle. Then → FETCH, or → DONE if the latched length is 0.
  - FETCH: `rd_en`=1 and `rd_addr` = 0, 1, … len-1 on consecutive cycles. After the cycle with `rd_addr`=len-1 → DRAIN1.
  - DRAIN1 → DRAIN2 → DONE. `rd_en`=0 in both.
  - DONE: `result` ← `mac_out` on the exiting edge. → IDLE.
- `done` is registered and is high in the first IDLE cycle after DONE.
- Enable alignment:
  - `mac_mul_en` = `rd_en` delayed 1 cycle, which is the cycle read data is valid.
  - `mac_ac_en` = `rd_en` delayed 2 cycles.
  - Both come from a 2-bit shift register cleared by reset, CLEAR and abort.
- `cfg_len` > 2^ADDR_WIDTH is clamped to 2^ADDR_WIDTH. No wrap-around of `rd_addr`.
- Arithmetic: 2^6 × 255 × 255 = 4,161,600 < 2^22, so default parameters cannot overflow. The controller performs no saturation.
- `start` outside IDLE is ignored and is not queued.
- `abort` in any non-IDLE state:
  - Next state is IDLE.
  - `rd_en`, `mac_mul_en` and `mac_ac_en` are forced to 0 from the next cycle, and the delay line is flushed.
  - No `done`; `result` is unchanged.
  - `abort` has priority over all other transitions.
  - `abort` in IDLE has no effect. If `abort` and `start` are both high in IDLE, `start` is accepted.
- Reset asserted mid-operation returns the FSM to IDLE immediately with all outputs 0. The MAC is cleared by the next CLEAR, not by reset.
- `start` accepted in the same cycle `done` is high is legal and gives back-to-back operations.

## Timing
Cycle 0 is the cycle in which `start` is sampled high in IDLE; N is the clamped length.
- Cycle 1: CLEAR.
- Cycles 2..N+1: FETCH.
- Cycles N+2, N+3: DRAIN1, DRAIN2.
- Cycle N+4: DONE.
- Cycle N+5: `done`=1 and `result` valid.
- `busy` is high in cycles 1..N+4.
- N=0: CLEAR in cycle 1, DONE in cycle 2, `done` in cycle 3 with `result`=0.
- Last `mac_ac_en` is in cycle N+3. `mac_out` is final in cycle N+4.
- Back-to-back throughput is one dot product per N+5 cycles.

## Structure
- Shared package `mac_pkg`:
  - `mac_ctrl_state_t` enum: IDLE, CLEAR, FETCH, DRAIN1, DRAIN2, DONE.
  - localparams `RD_LAT`=1 and `MAC_LAT`=2, used to size the enable delay line and the drain.
- No sub-module. `mac_ctrl` does not instantiate the MAC; the parent connects both.

## Test plan
- Reset, then `start` with `cfg_len`=4, image 1,2,3,4 and weights 5,6,7,8 → `rd_addr` 0..3 in cycles 2..5, `done` in cycle 9, `result`=70.
- `cfg_len`=64 with all operands 255 → `result`=4,161,600 with no overflow. `cfg_len`=100 clamps to 64, giving the same result.
- `cfg_len`=0 → `done` in cycle 3, `result`=0, and `rd_en`, `mac_mul_en`, `mac_ac_en` never asserted.
- `abort` in FETCH at `rd_addr`=2 → IDLE next cycle, all enables 0 within 1 cycle, no `done`, previous `result` retained. A new `start` then gives a correct result.
- `start` held high continuously with `cfg_len`=3 → consecutive `done` pulses 8 cycles apart. A `start` pulse while `busy` is ignored.
- `rst_n` pulsed low during DRAIN1 → all outputs 0 asynchronously, FSM in IDLE, no `done`.
